// File: rtl/sched_pkg.sv
// Shared types and elaboration-time helpers for the tick scheduler.
// Holds the arbiter state encoding, timebase divider and channel-index width.
package sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_t;

    function automatic int tick_div(input int clock_frequency, input int tick_hz);
        return clock_frequency / tick_hz;
    endfunction

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timebase prescaler: one-cycle tick every CLOCK_FREQUENCY/TICK_HZ enabled cycles.
// Latency: tick registered, high on the cycle after the count wraps.
// Backpressure: none; count holds while enable is low.
module tick_prescaler
    import sched_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TICK_HZ         = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int TICK_DIV = tick_div(CLOCK_FREQUENCY, TICK_HZ);
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    tick  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Periodic scheduler: per-channel tick countdowns feed a round-robin start/done grant slot.
// Latency: tick in T, pending in T+1, start in T+2 when idle. Optional SCHED_WATCHDOG_EN adds grant timeout.
// Backpressure: a grant holds start until done (or timeout); re-expiry while pending raises sticky overrun.
module tick_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TICK_HZ         = 1000,
    parameter int PERIOD_W        = 16
`ifdef SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT_TICKS   = 8
`endif
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [PERIOD_W-1:0]         cfg_period,
    input  logic [NUM_CH-1:0]           done,
    output logic [NUM_CH-1:0]           start,
    output logic                        busy,
    output logic                        tick,
    output logic [NUM_CH-1:0]           overrun,
    input  logic                        overrun_clr
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic [NUM_CH-1:0]           timeout
`endif
);

    localparam int IDX_W = ch_idx_w(NUM_CH);
    typedef logic [IDX_W-1:0] idx_t;

    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] cnt_q    [NUM_CH];
    logic [NUM_CH-1:0]   pending_q;
    logic [NUM_CH-1:0]   wr_hit;
    logic [NUM_CH-1:0]   expire;
    logic [NUM_CH-1:0]   clr_req;
    logic [NUM_CH-1:0]   ovr_set;
    logic [NUM_CH-1:0]   arb_req;
    sched_state_t        state_q;
    idx_t                rr_ptr_q;
    idx_t                arb_sel;
    idx_t                cand;
    logic                arb_vld;
    logic                grant_end;
    logic                abort;

    tick_prescaler #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .TICK_HZ         (TICK_HZ)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign grant_end = (state_q == ST_GRANT) && (done[rr_ptr_q] || abort);

    always_comb begin
        clr_req = '0;
        if (grant_end) begin
            clr_req[rr_ptr_q] = 1'b1;
        end
    end

    // A config write wins over any expiry or completion on the same channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]  = cfg_we && (cfg_ch == idx_t'(i));
            expire[i]  = tick && (period_q[i] != '0) && (cnt_q[i] == '0);
            ovr_set[i] = expire[i] && !wr_hit[i] && pending_q[i] && !clr_req[i];
        end
    end

    assign arb_req = pending_q & ~wr_hit;

    always_comb begin
        arb_vld = 1'b0;
        arb_sel = rr_ptr_q;
        cand    = rr_ptr_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = idx_t'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!arb_vld && arb_req[cand]) begin
                arb_vld = 1'b1;
                arb_sel = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            pending_q <= '0;
            overrun   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    period_q[i]  <= cfg_period;
                    cnt_q[i]     <= (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
                    pending_q[i] <= 1'b0;
                end else begin
                    if (expire[i]) begin
                        pending_q[i] <= 1'b1;
                    end else if (clr_req[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (tick && (period_q[i] != '0)) begin
                        cnt_q[i] <= (cnt_q[i] == '0) ? period_q[i] - PERIOD_W'(1)
                                                     : cnt_q[i] - PERIOD_W'(1);
                    end
                end
            end
            overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_set;
        end
    end

    // rr_ptr_q doubles as the granted channel while in GRANT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= idx_t'(NUM_CH - 1);
            start    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        start    <= NUM_CH'(1) << arb_sel;
                        busy     <= 1'b1;
                        rr_ptr_q <= arb_sel;
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_end) begin
                        start   <= '0;
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);

    logic [WD_W-1:0] wd_cnt_q;

    assign abort = (state_q == ST_GRANT) && tick && !done[rr_ptr_q] &&
                   (wd_cnt_q == WD_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
            timeout  <= '0;
        end else begin
            if (state_q == ST_GRANT) begin
                if (tick) begin
                    wd_cnt_q <= wd_cnt_q + WD_W'(1);
                end
            end else begin
                wd_cnt_q <= '0;
            end
            timeout <= (timeout & ~{NUM_CH{overrun_clr}}) | (abort ? clr_req : '0);
        end
    end
`else
    assign abort = 1'b0;
`endif

endmodule
